sha256_block_ctrl: RTL and testbench

- Sequences one SHA-256 compression per 512-bit block.
- Owns the eight hash-state words H0..H7 and issues load/round strobes plus round index to the round datapath and message schedule.
- On completion, folds the working variables a..h back into H0..H7 with modulo-2^32 adds.
- Replaces the per-word toggle-driven H registers with a single clocked controller.

---
 rtl/sha256_block_ctrl_if.sv | 25 ++
 rtl/sha256_block_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sha256_block_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sha256_block_ctrl_if.sv
// Handshake and data bundle between the SHA-256 block controller and the
// block source / round datapath that surround it.
interface sha256_block_ctrl_if;
    logic         start;
    logic         first_block;
    logic         abort;
    logic [255:0] work_in;
    logic         ready;
    logic         load_work;
    logic         round_en;
    logic [5:0]   round_idx;
    logic         w_load;
    logic [255:0] h_state;
    logic         done;

    modport master (
        output start, first_block, abort, work_in,
        input  ready, load_work, round_en, round_idx, w_load, h_state, done
    );

    modport slave (
        input  start, first_block, abort, work_in,
        output ready, load_work, round_en, round_idx, w_load, h_state, done
    );
endinterface

// File: rtl/sha256_block_ctrl.sv
// SHA-256 per-block sequencer: owns H0..H7, drives load/round strobes and the
// round index, and folds the working variables back into H when a block ends.
module sha256_block_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int MSG_WORDS  = 16
) (
    input  logic               clk,
    input  logic               rst,
    sha256_block_ctrl_if.slave bus
);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);
    localparam logic       W_LOAD_ROUND0 = (MSG_WORDS > 0);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        ROUND,
        UPDATE,
        DONE
    } state_t;

    state_t       state_reg;
    logic [255:0] h_reg;
    logic [255:0] h_sum;
    logic [5:0]   round_idx_reg;
    logic         first_block_reg;
    logic         ready_reg;
    logic         load_work_reg;
    logic         round_en_reg;
    logic         w_load_reg;
    logic         done_reg;

    logic [6:0]   idx_inc;
    logic         w_load_next;

    assign idx_inc     = {1'b0, round_idx_reg} + 7'd1;
    assign w_load_next = (idx_inc < 7'(MSG_WORDS));

    // Eight independent 32-bit adders: no carry crosses a word boundary.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fold
            assign h_sum[255 - 32*gi -: 32] = h_reg[255 - 32*gi -: 32]
                                            + bus.work_in[255 - 32*gi -: 32];
        end
    endgenerate

    // Strobes default low each cycle and are re-asserted only for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            h_reg           <= IV;
            round_idx_reg   <= '0;
            first_block_reg <= 1'b0;
            ready_reg       <= 1'b1;
            load_work_reg   <= 1'b0;
            round_en_reg    <= 1'b0;
            w_load_reg      <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            ready_reg     <= 1'b0;
            load_work_reg <= 1'b0;
            round_en_reg  <= 1'b0;
            w_load_reg    <= 1'b0;
            done_reg      <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg       <= INIT;
                        first_block_reg <= bus.first_block;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end

                INIT: begin
                    if (bus.abort) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end else begin
                        if (first_block_reg) begin
                            h_reg <= IV;
                        end
                        state_reg     <= LOAD;
                        load_work_reg <= 1'b1;
                    end
                end

                LOAD: begin
                    round_idx_reg <= '0;
                    if (bus.abort) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end else begin
                        state_reg    <= ROUND;
                        round_en_reg <= 1'b1;
                        w_load_reg   <= W_LOAD_ROUND0;
                    end
                end

                ROUND: begin
                    if (bus.abort) begin
                        state_reg     <= IDLE;
                        round_idx_reg <= '0;
                        ready_reg     <= 1'b1;
                    end else if (round_idx_reg == LAST_IDX) begin
                        state_reg     <= UPDATE;
                        round_idx_reg <= '0;
                    end else begin
                        round_idx_reg <= idx_inc[5:0];
                        round_en_reg  <= 1'b1;
                        w_load_reg    <= w_load_next;
                    end
                end

                UPDATE: begin
                    if (bus.abort) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end else begin
                        h_reg     <= h_sum;
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end

                DONE: begin
                    // abort is deliberately ignored here so the digest pulse always completes
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg     <= IDLE;
                    round_idx_reg <= '0;
                    ready_reg     <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (round_idx_reg <= LAST_IDX);
            assert (!(round_en_reg && load_work_reg));
        end
    end

    assign bus.ready     = ready_reg;
    assign bus.load_work = load_work_reg;
    assign bus.round_en  = round_en_reg;
    assign bus.round_idx = round_idx_reg;
    assign bus.w_load    = w_load_reg;
    assign bus.h_state   = h_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Self-checking bench for sha256_block_ctrl: directed vector table, randomized
// blocks against a word-level hash-state model, and multi-cycle corner sequences.
module tb_sha256_block_ctrl;

    localparam int NUM_ROUNDS = 64;
    localparam int MSG_WORDS  = 16;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic clk;
    logic rst;
    sha256_block_ctrl_if bus ();

    sha256_block_ctrl #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .MSG_WORDS  (MSG_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] h_m [8];

    typedef struct {
        logic         fb;
        logic [255:0] work;
        int           abort_at;
        logic [31:0]  exp_h0;
        logic [31:0]  exp_h1;
        logic [31:0]  exp_h7;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_h();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h_m[i];
        return r;
    endfunction

    function automatic void model_set_iv();
        logic [255:0] iv_v;
        iv_v = IV;
        for (int i = 0; i < 8; i++) h_m[i] = iv_v[255 - 32*i -: 32];
    endfunction

    function automatic void model_fold(input logic [255:0] work);
        for (int i = 0; i < 8; i++) h_m[i] = h_m[i] + work[255 - 32*i -: 32];
    endfunction

    // Observes one accepted block, sampling after edges k..k+68 (m = 0..68).
    task automatic observe(input logic fb, input logic [255:0] work, input int abort_at,
                           input bit hold, input string tag);
        int lw_cnt = 0, lw_at = -1, re_cnt = 0, wl_cnt = 0;
        int done_cnt = 0, done_at = -1, seq_err = 0, exp_idx = 0;
        bit aborted = 0, abort_checked = 0;
        for (int m = 0; m <= 68; m++) begin
            @(negedge clk);
            if (m == 0) begin
                if (!hold) bus.start = 1'b0;
                check({tag, " accept_ready"}, 256'(bus.ready), 256'(0));
                if (fb) model_set_iv();
            end
            if (aborted) begin
                bus.abort = 1'b0;
                check({tag, " abort_ready"}, 256'(bus.ready), 256'(1));
                check({tag, " abort_round_en"}, 256'(bus.round_en), 256'(0));
                check({tag, " abort_no_done"}, 256'(done_cnt + int'(bus.done)), 256'(0));
                check({tag, " abort_h"}, bus.h_state, model_h());
                abort_checked = 1;
                break;
            end
            if (bus.load_work) begin lw_cnt++; lw_at = m; end
            if (bus.round_en) begin
                if (int'(bus.round_idx) != exp_idx) seq_err++;
                exp_idx++;
                re_cnt++;
            end
            if (bus.w_load !== (bus.round_en && int'(bus.round_idx) < MSG_WORDS)) seq_err++;
            if (bus.w_load) wl_cnt++;
            if (bus.done) begin done_cnt++; done_at = m; end
            if (abort_at >= 0 && bus.round_en && int'(bus.round_idx) == abort_at) begin
                bus.abort = 1'b1;
                aborted = 1;
            end
        end
        if (abort_at >= 0) begin
            if (!abort_checked) begin
                bus.abort = 1'b0;
                check({tag, " abort_reached"}, 256'(0), 256'(1));
            end
        end else begin
            model_fold(work);
            check({tag, " load_work_at"}, 256'(lw_at), 256'(1));
            check({tag, " load_work_cnt"}, 256'(lw_cnt), 256'(1));
            check({tag, " round_en_cnt"}, 256'(re_cnt), 256'(NUM_ROUNDS));
            check({tag, " w_load_cnt"}, 256'(wl_cnt), 256'(MSG_WORDS));
            check({tag, " idx_seq_err"}, 256'(seq_err), 256'(0));
            check({tag, " done_at"}, 256'(done_at), 256'(67));
            check({tag, " done_cnt"}, 256'(done_cnt), 256'(1));
            check({tag, " idle_ready"}, 256'(bus.ready), 256'(1));
            check({tag, " h_state"}, bus.h_state, model_h());
        end
    endtask

    task automatic run_block(input logic fb, input logic [255:0] work, input int abort_at,
                             input bit hold, input string tag);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.first_block = fb;
        bus.work_in     = work;
        observe(fb, work, abort_at, hold, tag);
    endtask

    initial begin
        logic [255:0] w;
        logic [255:0] hs;
        bit found;

        vecs[0] = '{1'b1, 256'h0, -1, 32'h6a09e667, 32'hbb67ae85, 32'h5be0cd19};
        vecs[1] = '{1'b0, {8{32'h00000001}}, -1, 32'h6a09e668, 32'hbb67ae86, 32'h5be0cd1a};
        vecs[2] = '{1'b1, 256'h0, -1, 32'h6a09e667, 32'hbb67ae85, 32'h5be0cd19};
        vecs[3] = '{1'b0, {32'h0, 32'h44985180, 192'h0}, -1, 32'h6a09e667, 32'h00000005, 32'h5be0cd19};
        vecs[4] = '{1'b0, {8{32'hffffffff}}, 10, 32'h6a09e667, 32'h00000005, 32'h5be0cd19};
        vecs[5] = '{1'b1, {8{32'h12345678}}, 10, 32'h6a09e667, 32'hbb67ae85, 32'h5be0cd19};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.first_block = 1'b0;
        bus.abort       = 1'b0;
        bus.work_in     = '0;
        model_set_iv();
        repeat (3) @(negedge clk);
        check("reset ready", 256'(bus.ready), 256'(1));
        check("reset h_state", bus.h_state, IV);
        check("reset strobes", 256'({bus.load_work, bus.round_en, bus.w_load, bus.done}), 256'(0));
        check("reset round_idx", 256'(bus.round_idx), 256'(0));
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_block(vecs[v].fb, vecs[v].work, vecs[v].abort_at, 1'b0, $sformatf("vec%0d", v));
            hs = bus.h_state;
            check($sformatf("vec%0d H0", v), 256'(hs[255:224]), 256'(vecs[v].exp_h0));
            check($sformatf("vec%0d H1", v), 256'(hs[223:192]), 256'(vecs[v].exp_h1));
            check($sformatf("vec%0d H7", v), 256'(hs[31:0]), 256'(vecs[v].exp_h7));
            $display("vec%0d fb=%0d abort_at=%0d h_state=%h", v, vecs[v].fb, vecs[v].abort_at, hs);
        end

        for (int r = 0; r < 16; r++) begin
            int ab;
            logic fbr;
            for (int i = 0; i < 8; i++) w[255 - 32*i -: 32] = $urandom;
            fbr = ($urandom_range(0, 3) == 0);
            ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NUM_ROUNDS - 1)) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_block(fbr, w, ab, 1'b0, $sformatf("rnd%0d", r));
            $display("rnd%0d fb=%0d abort_at=%0d h_state=%h", r, fbr, ab, bus.h_state);
        end

        // start held high across an accepted block: one block, then a fresh accept only after DONE
        for (int i = 0; i < 8; i++) w[255 - 32*i -: 32] = $urandom;
        run_block(1'b0, w, -1, 1'b1, "hold_first");
        observe(1'b0, w, -1, 1'b0, "hold_second");
        $display("hold sequence h_state=%h", bus.h_state);

        // reset in the middle of ROUND once H has moved away from IV
        for (int i = 0; i < 8; i++) w[255 - 32*i -: 32] = $urandom | 32'h1;
        run_block(1'b0, w, -1, 1'b0, "pre_reset");
        @(negedge clk);
        bus.start       = 1'b1;
        bus.first_block = 1'b0;
        found = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.round_en && bus.round_idx == 6'd30) begin found = 1; break; end
        end
        check("reset_mid_round reached", 256'(found), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_round ready", 256'(bus.ready), 256'(1));
        check("reset_mid_round round_en", 256'(bus.round_en), 256'(0));
        check("reset_mid_round round_idx", 256'(bus.round_idx), 256'(0));
        check("reset_mid_round h_state", bus.h_state, IV);
        $display("reset mid-round h_state=%h", bus.h_state);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
